// File: rtl/key_expansion_sched.sv
// AES-128 key expansion sequencer: emits round keys 0..NUM_ROUNDS over valid/ready,
// sharing one S-box across SubWord bytes (KEYEXP_PAR_SBOX_EN: four S-boxes, 1-cycle SUB).

module key_exp_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as din^254 via an addition chain; 0 maps to 0.
  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
  assign x2   = gmul(din, din);
  assign x3   = gmul(x2, din);
  assign x6   = gmul(x3, x3);
  assign x12  = gmul(x6, x6);
  assign x15  = gmul(x12, x3);
  assign x30  = gmul(x15, x15);
  assign x60  = gmul(x30, x30);
  assign x120 = gmul(x60, x60);
  assign x240 = gmul(x120, x120);
  assign x252 = gmul(x240, x12);
  assign inv  = gmul(x252, x2);

  assign dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module key_expansion_sched #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, EMIT, SUB, GEN} state_t;

  state_t      state, state_nxt;
  logic [7:0]  rcon;
  logic [31:0] temp;
  logic [31:0] rot;
  logic [31:0] t, w4, w5, w6, w7;
  logic        last;

  assign rot  = {round_key[23:0], round_key[31:24]};
  assign last = (rk_idx == 4'(NUM_ROUNDS));

`ifdef KEYEXP_PAR_SBOX_EN
  logic [3:0][7:0] sb_out;
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    key_exp_sbox u_sbox (.din(rot[8*i +: 8]), .dout(sb_out[i]));
  end
`else
  logic [1:0]      cnt;
  logic [3:0][7:0] rot_b;
  logic [7:0]      sb_out;
  assign rot_b = rot;
  // ~cnt selects byte 3-cnt of the packed word, i.e. MSB-first order.
  key_exp_sbox u_sbox (.din(rot_b[~cnt]), .dout(sb_out));
`endif

  always_comb begin
    t  = temp ^ {rcon, 24'h0};
    w4 = round_key[127:96] ^ t;
    w5 = round_key[95:64]  ^ w4;
    w6 = round_key[63:32]  ^ w5;
    w7 = round_key[31:0]   ^ w6;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)    state_nxt = EMIT;
      EMIT: if (rk_ready) state_nxt = last ? IDLE : SUB;
`ifdef KEYEXP_PAR_SBOX_EN
      SUB:  state_nxt = GEN;
`else
      SUB:  if (cnt == 2'd3) state_nxt = GEN;
`endif
      GEN:  state_nxt = EMIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rk_valid = (state == EMIT);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_key <= '0;
      rk_idx    <= '0;
      rcon      <= 8'h01;
      temp      <= '0;
      done      <= 1'b0;
`ifndef KEYEXP_PAR_SBOX_EN
      cnt       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          round_key <= key;
          rk_idx    <= '0;
          rcon      <= 8'h01;
        end
        EMIT: if (rk_ready) begin
          if (last) done <= 1'b1;
`ifndef KEYEXP_PAR_SBOX_EN
          cnt <= '0;
`endif
        end
`ifdef KEYEXP_PAR_SBOX_EN
        SUB: temp <= sb_out;
`else
        SUB: begin
          temp <= {temp[23:0], sb_out};
          cnt  <= cnt + 2'd1;
        end
`endif
        GEN: begin
          round_key <= {w4, w5, w6, w7};
          rk_idx    <= rk_idx + 4'd1;
          rcon      <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_key_expansion_sched.sv
// Scoreboarded bench for key_expansion_sched: reference key schedule built from
// a brute-force S-box table, randomized keys/backpressure, reset abort, NUM_ROUNDS=2.

module tb_key_expansion_sched;
`ifdef KEYEXP_PAR_SBOX_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 5;
`endif
  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0, rk_ready = 1'b0;
  logic [127:0] key = '0;
  logic         rk_valid, busy, done;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;

  logic         start2 = 1'b0, rk_ready2 = 1'b1;
  logic [127:0] key2 = '0;
  logic         rk_valid2, busy2, done2;
  logic [3:0]   rk_idx2;
  logic [127:0] round_key2;

  key_expansion_sched #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .rk_ready(rk_ready),
    .rk_valid(rk_valid), .rk_idx(rk_idx), .round_key(round_key), .busy(busy), .done(done));

  key_expansion_sched #(.NUM_ROUNDS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .key(key2), .rk_ready(rk_ready2),
    .rk_valid(rk_valid2), .rk_idx(rk_idx2), .round_key(round_key2), .busy(busy2), .done(done2));

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] rk;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [7:0]   sbt [256];
  logic [127:0] mrk [0:10];
  logic [127:0] mrk2 [0:10];
  logic [127:0] seen [0:15];
  int tests = 0, fails = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0;
  int n2 = 0, done2_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // FIPS-197 word-wise schedule w[0..43].
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbt[tmp[31:24]], sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]]}
            ^ {RCON[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_all();
    for (int r = 0; r <= 10; r++) exp_q.push_back(exp_t'{4'(r), mrk[r]});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [127:0] k, output int t0);
    key = k;
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int prev, input string name);
    int n = 0;
    while (done_cnt == prev && n < 1000) begin step(); n++; end
    if (done_cnt == prev) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idx(input logic [3:0] idx, input string name);
    int n = 0;
    while (!(rk_valid && rk_idx == idx) && n < 200) begin step(); n++; end
    if (!(rk_valid && rk_idx == idx)) chk({name, "_timeout"}, 0, 1);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (rk_valid && rk_ready) begin
      if (exp_q.size() == 0) chk("unexpected_rk", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("rk_idx", rk_idx, mon_e.idx);
        chk("round_key", round_key, mon_e.rk);
        seen[rk_idx] = round_key;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_excl_valid", rk_valid, 0);
    end
    if (rk_valid2 && rk_ready2) begin
      chk("nr2_idx", rk_idx2, 4'(n2));
      chk("nr2_key", round_key2, (n2 <= 10) ? mrk2[n2] : '0);
      n2++;
    end
    if (done2) begin
      done2_cnt++;
      chk("nr2_done_excl", rk_valid2, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, d0, h, n;
    logic [127:0] cap, k;
    logic ok;

    build_sbox();
    step(); step();
    chk("rst_valid", rk_valid, 0);
    chk("rst_idx", rk_idx, 0);
    chk("rst_key", round_key, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    rk_ready = 1'b1;
    step();

    // FIPS-197 vector, no backpressure
    expand(FIPS_KEY); push_all();
    d0 = done_cnt;
    start_run(FIPS_KEY, t0);
    wait_done(d0, "fips");
    chk("fips_done_lat", done_cyc - t0, 1 + 10 * (LAT + 1));
    step(); step(); step();
    chk("fips_done_once", done_cnt - d0, 1);
    chk("fips_rk0", seen[0], FIPS_KEY);
    chk("fips_rk1", seen[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_rk10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_idle", busy, 0);

    // all-zero key
    expand('0); push_all();
    d0 = done_cnt;
    start_run('0, t0);
    wait_done(d0, "zero");
    chk("zero_rk1", seen[1], 128'h62636363626363636263636362636363);
    chk("zero_rk2", seen[2], 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);

    // backpressure at rk_idx 3
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k); push_all();
    d0 = done_cnt;
    start_run(k, t0);
    wait_idx(4'd3, "bp_idx3");
    rk_ready = 1'b0;
    cap = round_key;
    ok = 1'b1;
    repeat (20) begin
      step();
      ok &= rk_valid && (rk_idx == 4'd3) && (round_key == cap) && busy;
    end
    chk("bp_stable", ok, 1);
    rk_ready = 1'b1;
    step();
    h = cyc;
    n = 0;
    while (!rk_valid && n < 20) begin step(); n++; end
    chk("bp_latency", cyc - h, LAT);
    chk("bp_idx4", rk_idx, 4);
    wait_done(d0, "bp");

    // random keys, random ready, stray start pulses while busy
    repeat (3) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k); push_all();
      d0 = done_cnt;
      start_run(k, t0);
      n = 0;
      while (done_cnt == d0 && n < 2000) begin
        rk_ready = ($urandom_range(0, 3) != 0);
        if (busy && rk_idx < 4'd8 && $urandom_range(0, 5) == 0) begin
          start = 1'b1;
          key = {$urandom, $urandom, $urandom, $urandom};
        end else start = 1'b0;
        step();
        n++;
      end
      start = 1'b0;
      rk_ready = 1'b1;
      if (done_cnt == d0) chk("rand_timeout", 0, 1);
      step();
      chk("rand_idle", busy, 0);
    end

    // async reset while generating round 5
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k); push_all();
    start_run(k, t0);
    wait_idx(4'd4, "rst_idx4");
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", rk_valid, 0);
    chk("arst_idx", rk_idx, 0);
    chk("arst_key", round_key, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k); push_all();
    d0 = done_cnt;
    start_run(k, t0);
    wait_done(d0, "post_rst");
    chk("post_rst_rk0", seen[0], k);

    // NUM_ROUNDS = 2 instance
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k);
    mrk2 = mrk;
    n2 = 0;
    key2 = k;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    n = 0;
    while (done2_cnt == 0 && n < 100) begin step(); n++; end
    chk("nr2_count", n2, 3);
    step(); step();
    chk("nr2_idle", busy2, 0);
    chk("nr2_done_once", done2_cnt, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_expansion_sched.md
Name: key_expansion_sched

Overview:
- Sequencer for AES-128 key expansion that time-multiplexes a single S_box instance across the four SubWord bytes.
- Accepts a 128-bit cipher key and emits round keys 0..NUM_ROUNDS in order over a valid/ready stream.
- Sits between the key-load path and the round datapath.
- Trades area (one S-box instead of four) for a 5-cycle per-round key generation latency.

Parameters:
- NUM_ROUNDS, 10, index of the last round key emitted; legal range 1..10. Out-of-range values are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new expansion; sampled only in IDLE.
- key  input  128  cipher key, captured on start acceptance; key[127:96]=w0, byte 0 = w[31:24].
- rk_ready  input  1  consumer ready for the current round key.
- rk_valid  output  1  round_key/rk_idx valid.
- rk_idx  output  4  round number of round_key (0..NUM_ROUNDS).
- round_key  output  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last round key handshake.

Behaviour:
- Reset (async, rst_n low): state=IDLE; rk_valid=0, rk_idx=0, round_key=0, busy=0, done=0; rcon=8'h01; byte counter=0.
- Reset mid-operation aborts immediately with no further outputs. The consumer must discard any partial sequence.
- States: IDLE, EMIT, SUB, GEN.
- IDLE:
  - start=1 -> capture key into round_key, rk_idx=0, rcon=8'h01, go EMIT.
  - rk_valid rises the cycle after start is accepted.
  - start is ignored in every other state.
- EMIT:
  - rk_valid=1. round_key and rk_idx are held stable until rk_valid&rk_ready.
  - On handshake with rk_idx==NUM_ROUNDS -> IDLE, rk_valid=0, done=1 for one cycle.
  - On handshake otherwise -> SUB, rk_valid=0, byte counter=0.
- SUB (4 cycles, counter 0..3):
  - Let rot = {w3[23:0], w3[31:24]}.
  - In cycle k, S_box input = rot byte k (MSB first); output is registered into temp byte k.
  - After counter==3 -> GEN.
- GEN (1 cycle), with t = temp ^ {rcon, 24'h0}:
  - w4 = w0^t
  - w5 = w1^w4
  - w6 = w2^w5
  - w7 = w3^w6
  - Load {w4..w7} into round_key, rk_idx+1, rcon = xtime(rcon) (shift left; XOR 8'h1B if bit7 was set), go EMIT.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- Latency:
  - Handshake in EMIT -> next rk_valid: 5 cycles later (4 SUB + 1 GEN).
  - start -> rk_idx 0 valid: 1 cycle.
  - With rk_ready tied high, a full 10-round expansion completes in 1+10*6 cycles from start to done.
- Backpressure: rk_ready low holds EMIT indefinitely. The S-box is idle during EMIT.
- done and rk_valid are never high in the same cycle.

Optional Feature:
- Macro: KEYEXP_PAR_SBOX_EN.
- Defined:
  - Four S_box instances substitute all rot bytes in one cycle; SUB is a single cycle.
  - Handshake -> next rk_valid latency = 2 cycles.
  - All other behaviour, ports and values are identical.
- Undefined: single shared S_box, 4-cycle SUB as specified above.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - rk_idx0 = key.
  - rk_idx1 = a0fafe1788542cb123a339392a6c7605.
  - rk_idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done pulses once, 61 cycles after start.
- All-zero key -> rk_idx1 = 62636363626363636263636362636363; rk_idx2 = 9b9898c9f9fbfbaa9b9898c9f9fbfbaa.
- Backpressure: hold rk_ready=0 for 20 cycles at rk_idx3 -> round_key/rk_idx stable and busy=1; after release, rk_idx4 is valid exactly 5 cycles after the handshake.
- start pulsed while busy -> ignored; sequence continues unchanged.
- Assert rst_n low during SUB of round 5 -> outputs clear asynchronously. A new start after release yields rk_idx0 with the new key and rcon restarted at 01.
- NUM_ROUNDS=2 -> emits rk_idx 0,1,2 only, then done, then busy=0.
